// File: rtl/apb_arbiter_master.sv
// -----------------------------------------------------------------------------
// apb_arbiter_master
//
// Two-requester APB master. Shares one APB completer between two on-chip
// clients using round-robin arbitration, sequences the IDLE/SETUP/ACCESS
// phases, waits on pready with a bounded timeout, and returns read data and
// error status to the requester that was granted.
//
// State table:
//   state  | meaning
//   IDLE   | bus idle; may accept one request (req_ready one-hot, comb)
//   SETUP  | psel=1, penable=0; timeout counter cleared
//   ACCESS | psel=1, penable=1; waiting for pready or timeout
//
// Ports:
//   pclk, presetn              clock (rising edge), async active-low reset
//   req_valid[1:0]             per-requester request, held until accepted
//   req_write[1:0]             per-requester direction (1 = write)
//   req_addr[2*AW-1:0]         packed addresses, requester i at [i*AW +: AW]
//   req_wdata[2*DW-1:0]        packed write data, requester i at [i*DW +: DW]
//   req_ready[1:0]             one-hot accept, combinational in IDLE
//   rsp_valid[1:0]             one-hot one-cycle completion pulse
//   rsp_rdata, rsp_err         response data / error, valid with rsp_valid
//   psel, penable, pwrite,
//   paddr, pwdata              APB request side
//   pready, pslverr, prdata    APB completer status
// -----------------------------------------------------------------------------
module apb_arbiter_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [2*AW-1:0]   req_addr,
    input  logic [2*DW-1:0]   req_wdata,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DW-1:0]     prdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          gnt_sel;
    logic          any_req;

    // Round-robin pick. With both requesting, the one not granted last wins;
    // with a single requester, that one wins. Value is don't-care when idle.
    always_comb begin
        any_req = |req_valid;
        if (req_valid == 2'b11) begin
            gnt_sel = ~last_q;
        end else begin
            gnt_sel = ~req_valid[0];
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && any_req) begin
            req_ready[gnt_sel] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d    = gnt_sel;
                    last_d   = gnt_sel;
                    pwrite_d = gnt_sel ? req_write[1] : req_write[0];
                    paddr_d  = gnt_sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    pwdata_d = gnt_sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // cnt_q counts ACCESS cycles already spent without pready,
                // so cnt_q == TIMEOUT-1 marks the TIMEOUT-th ACCESS cycle.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (pready) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = pslverr;
                    rsp_rdata_d        = pwrite_q ? '0 : prdata;
                    state_d            = IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    rsp_rdata_d        = '0;
                    state_d            = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Bus control decodes straight from the state register so that an
    // asynchronous reset drops psel/penable without waiting for a clock edge.
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
module tb_apb_arbiter_master;

    localparam int TO = 16;

    logic        pclk;
    logic        presetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int checks = 0;
    int errors = 0;

    apb_arbiter_master #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Completer: 32-word RAM, pready after wait_n stalled ACCESS cycles,
    // pslverr for addresses beyond the RAM.
    logic [31:0] smem [32];
    int          sacc;
    int          wait_n;

    assign pready  = psel && penable && (sacc >= wait_n);
    assign pslverr = pready && (paddr > 32'd31);
    assign prdata  = (psel && !pwrite && paddr < 32'd32) ? smem[paddr[4:0]] : 32'd0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sacc = 0;
            for (int i = 0; i < 32; i++) smem[i] = 32'd0;
        end else if (psel && penable) begin
            if (pready) begin
                if (pwrite && paddr < 32'd32) smem[paddr[4:0]] = pwdata;
                sacc = 0;
            end else begin
                sacc = sacc + 1;
            end
        end else begin
            sacc = 0;
        end
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One transfer from requester r; reports response and bus observations.
    task automatic xfer(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] rv, output logic [31:0] rd, output logic er,
                        output int nacc, output int lat, output logic stable, output logic idle_rsp);
        int n;
        @(negedge pclk);
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        req_write[r] = w;
        if (r == 0) begin req_addr[31:0] = a; req_wdata[31:0] = d; end
        else        begin req_addr[63:32] = a; req_wdata[63:32] = d; end
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 5) begin
            @(negedge pclk); #1; n++;
        end
        cmp("accept", {63'd0, req_ready[r]}, 64'd1);
        nacc = 0; stable = 1'b1;
        @(negedge pclk);
        req_valid = 2'b00;
        #1;
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 40) begin
            if (psel && penable) nacc++;
            if (psel && paddr !== a) stable = 1'b0;
            @(negedge pclk); #1; lat++;
        end
        rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
        idle_rsp = !psel && !penable;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  exp_rdy;
        logic        exp_err;
    } vec_t;
    vec_t tbl [8];

    logic [1:0]  rv;
    logic [31:0] rd;
    logic        er, stable, idle_rsp;
    int          nacc, lat;

    // random-phase reference state
    logic [31:0] mmem [32];
    logic [1:0]  mv, macc, exp_rdy, exp_rv;
    logic        mw [2];
    logic [31:0] ma [2];
    logic [31:0] md [2];
    logic        mlast, have_exp, exp_er;
    logic [31:0] exp_rd;
    int          exp_due, free_at, g, acc_len, wn;

    initial begin
        tbl[0] = '{2'b11, 32'd2,  32'd3,  2'b01, 1'b0};
        tbl[1] = '{2'b11, 32'd2,  32'd40, 2'b10, 1'b1};
        tbl[2] = '{2'b01, 32'd33, 32'd3,  2'b01, 1'b1};
        tbl[3] = '{2'b01, 32'd4,  32'd3,  2'b01, 1'b0};
        tbl[4] = '{2'b11, 32'd4,  32'd7,  2'b10, 1'b0};
        tbl[5] = '{2'b10, 32'd4,  32'd50, 2'b10, 1'b1};
        tbl[6] = '{2'b11, 32'd6,  32'd7,  2'b01, 1'b0};
        tbl[7] = '{2'b00, 32'd6,  32'd7,  2'b00, 1'b0};

        presetn = 1'b0; req_valid = 2'b00; req_write = 2'b00;
        req_addr = 64'd0; req_wdata = 64'd0; wait_n = 0;
        repeat (3) @(negedge pclk);
        #1;
        cmp("reset psel/penable/pwrite", {61'd0, psel, penable, pwrite}, 64'd0);
        cmp("reset paddr", paddr, 64'd0);
        cmp("reset pwdata", pwdata, 64'd0);
        cmp("reset rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        @(negedge pclk); presetn = 1'b1;
        #1;
        cmp("idle req_ready", req_ready, 64'd0);

        // write then read, requester 0
        xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("wr rsp_valid", rv, 2'b01);
        cmp("wr latency", lat, 3);
        cmp("wr err", er, 1'b0);
        xfer(0, 1'b0, 32'd5, 32'd0, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("rd rsp_valid", rv, 2'b01);
        cmp("rd data", rd, 32'hDEADBEEF);
        cmp("rd latency", lat, 3);

        // wait states
        wait_n = 3;
        xfer(1, 1'b0, 32'd5, 32'd0, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("ws access cycles", nacc, 4);
        cmp("ws paddr stable", stable, 1'b1);
        cmp("ws latency", lat, 6);
        cmp("ws rsp", {rv, rd}, {2'b10, 32'hDEADBEEF});

        // slave error
        wait_n = 0;
        xfer(0, 1'b0, 32'd40, 32'd0, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("slverr err", er, 1'b1);
        cmp("slverr rsp_valid", rv, 2'b01);

        // timeout
        wait_n = 100;
        xfer(1, 1'b0, 32'd5, 32'd0, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("to access cycles", nacc, TO);
        cmp("to latency", lat, TO + 2);
        cmp("to rsp", {rv, er, rd}, {2'b10, 1'b1, 32'd0});
        cmp("to bus idle", idle_rsp, 1'b1);

        // pready on the final allowed ACCESS cycle wins over timeout
        wait_n = TO - 1;
        xfer(0, 1'b0, 32'd5, 32'd0, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("edge access cycles", nacc, TO);
        cmp("edge rsp", {rv, er, rd}, {2'b01, 1'b0, 32'hDEADBEEF});
        xfer(1, 1'b0, 32'd40, 32'd0, rv, rd, er, nacc, lat, stable, idle_rsp);
        cmp("edge slverr", {rv, er}, {2'b10, 1'b1});

        // reset in the middle of ACCESS
        wait_n = 100;
        @(negedge pclk);
        req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'd3;
        @(negedge pclk); req_valid = 2'b00;
        begin
            int n;
            n = 0;
            while (!penable && n < 10) begin @(negedge pclk); n++; end
        end
        @(posedge pclk); #2;
        cmp("pre-reset penable", penable, 1'b1);
        presetn = 1'b0;
        #1;
        cmp("async reset psel/penable", {psel, penable}, 2'b00);
        cmp("async reset paddr", paddr, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk); #1;
            cmp("no rsp in reset", rsp_valid, 2'b00);
        end
        wait_n = 0;
        @(negedge pclk);
        presetn = 1'b1;
        req_valid = 2'b11; req_write = 2'b00;
        req_addr = {32'd9, 32'd8};
        #1;
        cmp("post-reset grant", req_ready, 2'b01);

        // contention: both hold requests for 8 reads total
        begin
            int expg, prev, t, gap;
            expg = 0; prev = 0; t = 0; gap = 0;
            for (int s = 0; s < 40 && t < 8; s++) begin
                if (s > 0) begin @(negedge pclk); #1; end
                if (req_ready != 2'b00) begin
                    cmp("cont grant", req_ready, (expg == 0) ? 2'b01 : 2'b10);
                    if (t > 0) begin
                        cmp("cont spacing", gap, 3);
                        cmp("cont rsp", rsp_valid, (prev == 0) ? 2'b01 : 2'b10);
                    end
                    prev = expg; expg = 1 - expg; t++; gap = 0;
                end
                gap++;
            end
            cmp("cont count", t, 8);
            @(negedge pclk); req_valid = 2'b00; #1;
            for (int n = 0; n < 10 && rsp_valid == 2'b00; n++) begin @(negedge pclk); #1; end
            cmp("cont last rsp", rsp_valid, 2'b10);
        end

        // arbitration table (pointer is at requester 1 here)
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            req_valid = tbl[i].v; req_write = 2'b00;
            req_addr = {tbl[i].a1, tbl[i].a0};
            #1;
            cmp("tbl ready", req_ready, tbl[i].exp_rdy);
            if (tbl[i].exp_rdy != 2'b00) begin
                @(negedge pclk); req_valid = 2'b00; #1;
                for (int n = 0; n < 10 && rsp_valid == 2'b00; n++) begin @(negedge pclk); #1; end
                cmp("tbl rsp", rsp_valid, tbl[i].exp_rdy);
                cmp("tbl err", rsp_err, tbl[i].exp_err);
            end
        end

        // randomized traffic against a transaction-level model
        @(negedge pclk); presetn = 1'b0; req_valid = 2'b00;
        @(negedge pclk); presetn = 1'b1;
        for (int i = 0; i < 32; i++) mmem[i] = 32'd0;
        mv = 2'b00; macc = 2'b00; mlast = 1'b1; have_exp = 1'b0;
        exp_due = 0; free_at = 0;
        for (int i = 0; i < 2; i++) begin mw[i] = 1'b0; ma[i] = 32'd0; md[i] = 32'd0; end
        for (int n = 0; n < 600; n++) begin
            @(negedge pclk);
            for (int i = 0; i < 2; i++) begin
                if (macc[i]) mv[i] = 1'b0;
                if (!mv[i] && n < 560 && $urandom_range(0, 2) != 0) begin
                    mv[i] = 1'b1;
                    mw[i] = 1'($urandom_range(0, 1));
                    ma[i] = $urandom_range(0, 35);
                    md[i] = $urandom;
                end
            end
            req_valid = mv;
            req_write = {mw[1], mw[0]};
            req_addr  = {ma[1], ma[0]};
            req_wdata = {md[1], md[0]};
            #1;
            if (have_exp && exp_due == n) begin
                cmp("rnd rsp_valid", rsp_valid, exp_rv);
                cmp("rnd rsp", {er_pad(rsp_err), rsp_rdata}, {er_pad(exp_er), exp_rd});
                have_exp = 1'b0;
            end else begin
                cmp("rnd no rsp", rsp_valid, 2'b00);
            end
            exp_rdy = 2'b00;
            if (n >= free_at && mv != 2'b00) begin
                if (mv == 2'b11) g = mlast ? 0 : 1;
                else             g = mv[0] ? 0 : 1;
                exp_rdy[g] = 1'b1;
            end
            cmp("rnd ready", req_ready, exp_rdy);
            macc = exp_rdy;
            if (exp_rdy != 2'b00) begin
                mlast = (g == 1);
                wn = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
                wait_n = wn;
                acc_len = (wn < TO) ? wn + 1 : TO;
                exp_rv = exp_rdy;
                if (wn >= TO) begin
                    exp_er = 1'b1; exp_rd = 32'd0;
                end else if (ma[g] > 32'd31) begin
                    exp_er = 1'b1; exp_rd = 32'd0;
                end else if (mw[g]) begin
                    mmem[ma[g][4:0]] = md[g];
                    exp_er = 1'b0; exp_rd = 32'd0;
                end else begin
                    exp_er = 1'b0; exp_rd = mmem[ma[g][4:0]];
                end
                exp_due  = n + 2 + acc_len;
                free_at  = exp_due;
                have_exp = 1'b1;
            end
        end
        cmp("rnd drained", {63'd0, have_exp}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [31:0] er_pad(input logic e);
        return {31'd0, e};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
